// File: rtl/pid_cal_unit.sv
// pid_cal_unit: incremental (velocity-form) PID calculator, Q1.15 in/out.
// One sample per enable strobe:
//   out += (Kp*(e-e1) + Ki*e + Kd*(e-2*e1+e2)) >>> 15, saturated to +/-32767.
// A single multiplier is time-shared across the P, I and D product states.
// Build option: define PID_D_TERM_EN to include the derivative path
// (MUL_D state, e2 history, Kd). Without it Kd is ignored and latency is 5.
module pid_cal_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         pid_cal_enable_in,
  input  logic signed [DATA_WIDTH-1:0] pid_param_p_in,
  input  logic signed [DATA_WIDTH-1:0] pid_param_i_in,
  input  logic signed [DATA_WIDTH-1:0] pid_param_d_in,
  input  logic signed [DATA_WIDTH-1:0] set_value_in,
  input  logic signed [DATA_WIDTH-1:0] detect_value_in,
  output logic signed [DATA_WIDTH-1:0] pid_cal_value_out,
  output logic                         pid_cal_done_out
);

  localparam int E_W    = DATA_WIDTH + 1;         // error e
  localparam int DP_W   = DATA_WIDTH + 2;         // e - e1
  localparam int DD_W   = DATA_WIDTH + 3;         // e - 2*e1 + e2
  localparam int PROD_W = DATA_WIDTH + DD_W;      // gain * widest difference
  localparam int SUM_W  = 2 * DATA_WIDTH + 8;     // three products, with headroom
  localparam int ACC_W  = DATA_WIDTH + 8;         // out + delta
  localparam int FRAC   = DATA_WIDTH - 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL_P,
    S_MUL_I,
`ifdef PID_D_TERM_EN
    S_MUL_D,
`endif
    S_ACC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched sample
  logic signed [DATA_WIDTH-1:0] kp_q, ki_q, set_q, detect_q;
  // Error terms and history
  logic signed [E_W-1:0]        e_q, e1_q;
  logic signed [DP_W-1:0]       dp_q;
  // Arithmetic pipeline
  logic signed [SUM_W-1:0]      sum_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [DATA_WIDTH-1:0] out_q;
  logic                         done_q;

  // Combinational datapath
  logic signed [E_W-1:0]        e_next;
  logic signed [DP_W-1:0]       dp_next;
  logic signed [DATA_WIDTH-1:0] mul_a;
  logic signed [DD_W-1:0]       mul_b;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_next;
  logic signed [DATA_WIDTH-1:0] sat_value;

`ifdef PID_D_TERM_EN
  logic signed [DATA_WIDTH-1:0] kd_q;
  logic signed [E_W-1:0]        e2_q;
  logic signed [DD_W-1:0]       dd_q;
  logic signed [DD_W-1:0]       dd_next;
`else
  // Kd has no use when the derivative path is not built.
  logic unused_d_gain;
  assign unused_d_gain = ^pid_param_d_in;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state sequencing; enable only matters in IDLE, so strobes while busy are dropped
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pid_cal_enable_in) state_d = S_ERR;
      S_ERR:   state_d = S_MUL_P;
      S_MUL_P: state_d = S_MUL_I;
`ifdef PID_D_TERM_EN
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_ACC;
`else
      S_MUL_I: state_d = S_ACC;
`endif
      S_ACC:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared multiplier operand select: one gain/difference pair per product state
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      S_MUL_P: begin mul_a = kp_q; mul_b = DD_W'(dp_q); end
      S_MUL_I: begin mul_a = ki_q; mul_b = DD_W'(e_q);  end
`ifdef PID_D_TERM_EN
      S_MUL_D: begin mul_a = kd_q; mul_b = dd_q;        end
`endif
      default: begin mul_a = '0;   mul_b = '0;          end
    endcase
  end

  assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);

  // Error and difference terms; the error is intentionally not saturated
  assign e_next  = E_W'(set_q) - E_W'(detect_q);
  assign dp_next = DP_W'(e_next) - DP_W'(e1_q);
`ifdef PID_D_TERM_EN
  assign dd_next = DD_W'(e_next) - (DD_W'(e1_q) <<< 1) + DD_W'(e2_q);
`endif

  // Arithmetic shift floors toward -inf; delta always fits in ACC_W
  assign acc_next = ACC_W'(out_q) + ACC_W'(sum_q >>> FRAC);

  // Clamp symmetrically to +/-(2^(W-1)-1)
  assign sat_value = (acc_q > ACC_MAX) ? DATA_WIDTH'(ACC_MAX) :
                     (acc_q < ACC_MIN) ? DATA_WIDTH'(ACC_MIN) :
                                         DATA_WIDTH'(acc_q);

  // Datapath registers: latch, difference, accumulate products, update output/history
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      kp_q     <= '0;
      ki_q     <= '0;
      set_q    <= '0;
      detect_q <= '0;
      e_q      <= '0;
      e1_q     <= '0;
      dp_q     <= '0;
      sum_q    <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
`ifdef PID_D_TERM_EN
      kd_q     <= '0;
      e2_q     <= '0;
      dd_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // e.g. e2 takes the old e1 while e1 takes e in the same DONE cycle.
      done_q <= (state_q == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (pid_cal_enable_in) begin
            kp_q     <= pid_param_p_in;
            ki_q     <= pid_param_i_in;
            set_q    <= set_value_in;
            detect_q <= detect_value_in;
`ifdef PID_D_TERM_EN
            kd_q     <= pid_param_d_in;
`endif
          end
        end
        S_ERR: begin
          e_q   <= e_next;
          dp_q  <= dp_next;
          sum_q <= '0;
`ifdef PID_D_TERM_EN
          dd_q  <= dd_next;
`endif
        end
        S_MUL_P, S_MUL_I: sum_q <= sum_q + SUM_W'(prod);
`ifdef PID_D_TERM_EN
        S_MUL_D:          sum_q <= sum_q + SUM_W'(prod);
`endif
        S_ACC:  acc_q <= acc_next;
        S_DONE: begin
          out_q <= sat_value;
          e1_q  <= e_q;
`ifdef PID_D_TERM_EN
          e2_q  <= e1_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign pid_cal_value_out = out_q;
  assign pid_cal_done_out  = done_q;

endmodule

// File: tb/tb_pid_cal_unit.sv
// tb_pid_cal_unit: table-driven directed vectors, hand-written reset-abort and
// busy-enable sequences, then randomized samples against a behavioural model.
module tb_pid_cal_unit;

`ifdef PID_D_TERM_EN
  localparam int LAT  = 6;
  localparam bit D_EN = 1'b1;
`else
  localparam int LAT  = 5;
  localparam bit D_EN = 1'b0;
`endif

  logic               sys_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               en      = 1'b0;
  logic signed [15:0] kp_in = '0, ki_in = '0, kd_in = '0, set_in = '0, det_in = '0;
  logic signed [15:0] out_w;
  logic               done_w;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: output and the two previous errors
  longint m_out, m_e1, m_e2;

  pid_cal_unit #(.DATA_WIDTH(16)) dut (
    .sys_clk           (sys_clk),
    .reset_n           (reset_n),
    .pid_cal_enable_in (en),
    .pid_param_p_in    (kp_in),
    .pid_param_i_in    (ki_in),
    .pid_param_d_in    (kd_in),
    .set_value_in      (set_in),
    .detect_value_in   (det_in),
    .pid_cal_value_out (out_w),
    .pid_cal_done_out  (done_w)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  function automatic int pick();
    case ($urandom_range(0, 3))
      0:       return 32767;
      1:       return -32767;
      2:       return 0;
      default: return rnd16();
    endcase
  endfunction

  // Velocity-form PID in plain integer arithmetic; floor division by 2^15.
  function automatic longint model_step(input int kp, input int ki, input int kd,
                                        input int sv, input int dv);
    longint e, s, acc;
    e = longint'(sv) - longint'(dv);
    s = longint'(kp) * (e - m_e1) + longint'(ki) * e;
    if (D_EN) s += longint'(kd) * (e - 2 * m_e1 + m_e2);
    acc = m_out + (s >>> 15);
    if (acc > 32767)       m_out = 32767;
    else if (acc < -32767) m_out = -32767;
    else                   m_out = acc;
    m_e2 = m_e1;
    m_e1 = e;
    return m_out;
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    m_out = 0; m_e1 = 0; m_e2 = 0;
  endtask

  task automatic drive(input int kp, input int ki, input int kd, input int sv, input int dv);
    kp_in  = 16'(kp);
    ki_in  = 16'(ki);
    kd_in  = 16'(kd);
    set_in = 16'(sv);
    det_in = 16'(dv);
  endtask

  // One accepted sample; returns the output and the done latency in cycles.
  // Returns half a cycle after done, so back-to-back calls enable at T+LAT+1.
  task automatic do_sample(input int kp, input int ki, input int kd, input int sv, input int dv,
                           output int got, output int lat);
    @(negedge sys_clk);
    drive(kp, ki, kd, sv, dv);
    en = 1'b1;
    @(posedge sys_clk);
    #1 check("done_low_at_enable", done_w, 0);
    @(negedge sys_clk);
    en = 1'b0;
    drive(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    lat = 0;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge sys_clk);
      #1;
      if (done_w) begin
        lat = c;
        got = int'(out_w);
        break;
      end
    end
  endtask

  typedef struct {
    bit do_reset;
    int kp, ki, kd, sv, dv;
    int exp_d, exp_nod;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got, lat, first, cnt, seen, exp;
    string nm;

    vecs[0] = '{1'b1,  6553,     0,     0, -32767, -32767,      0,      0};
    vecs[1] = '{1'b1, 32767,     0,     0,      0, -16383,  16382,  16382};
    vecs[2] = '{1'b1, 32767, 32767,     0,  32767, -32767,  32767,  32767};
    vecs[3] = '{1'b0, 32767, 32767,     0,  32767, -32767,  32767,  32767};
    vecs[4] = '{1'b1, 32767, 32767,     0, -32767,  32767, -32767, -32767};
    vecs[5] = '{1'b0, 32767, 32767,     0, -32767, -32767,  32765,  32765};
    vecs[6] = '{1'b1,     0,     0, 16384,  16384,      0,   8192,      0};
    vecs[7] = '{1'b0,     0,     0, 16384,      0,      0,  -8192,      0};
    vecs[8] = '{1'b0,     0,     0, 16384,      0,      0,      0,      0};

    // Reset state
    do_reset();
    @(posedge sys_clk);
    #1;
    check("reset_out", out_w, 0);
    check("reset_done", done_w, 0);

    // Directed vectors, back to back (each re-enable lands on the earliest edge)
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_reset) do_reset();
      exp = D_EN ? vecs[i].exp_d : vecs[i].exp_nod;
      do_sample(vecs[i].kp, vecs[i].ki, vecs[i].kd, vecs[i].sv, vecs[i].dv, got, lat);
      void'(model_step(vecs[i].kp, vecs[i].ki, vecs[i].kd, vecs[i].sv, vecs[i].dv));
      nm = $sformatf("vec%0d_out", i);
      check(nm, got, exp);
      nm = $sformatf("vec%0d_latency", i);
      check(nm, lat, LAT);
    end

    // Reset mid-computation: aborts, clears output and error history
    do_reset();
    do_sample(32767, 0, 0, 0, -16383, got, lat);
    check("abort_pre_out", got, 16382);
    @(negedge sys_clk);
    drive(32767, 32767, 0, 32767, -32767);
    en = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    en = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_in_reset", out_w, 0);
    check("abort_done_in_reset", done_w, 0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    m_out = 0; m_e1 = 0; m_e2 = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge sys_clk);
      #1 if (done_w) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_out_after", out_w, 0);
    // e=0 with Kp=1.0: a surviving e1=16383 would drive the output to -16383
    do_sample(32767, 0, 0, 0, 0, got, lat);
    void'(model_step(32767, 0, 0, 0, 0));
    check("abort_history_cleared", got, 0);

    // Enable while busy is ignored
    do_reset();
    @(negedge sys_clk);
    drive(32767, 0, 0, 0, -16383);
    en = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    en = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    drive(32767, 32767, 0, 32767, -32767);
    en = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    en = 1'b0;
    first = 0; cnt = 0; got = 0;
    for (int c = 5; c <= 24; c++) begin
      @(posedge sys_clk);
      #1;
      if (done_w) begin
        cnt++;
        if (first == 0) begin
          first = c;
          got = int'(out_w);
        end
      end
    end
    exp = int'(model_step(32767, 0, 0, 0, -16383));
    check("busy_latency", first, LAT);
    check("busy_out", got, exp);
    check("busy_done_count", cnt, 1);

    // Randomized samples against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      int kp, ki, kd, sv, dv;
      if (i % 2 == 0) begin
        kp = int'($urandom_range(0, 16384)) - 8192;
        ki = int'($urandom_range(0, 16384)) - 8192;
        kd = int'($urandom_range(0, 16384)) - 8192;
      end else begin
        kp = pick(); ki = pick(); kd = pick();
      end
      sv = pick();
      dv = pick();
      do_sample(kp, ki, kd, sv, dv, got, lat);
      exp = int'(model_step(kp, ki, kd, sv, dv));
      nm = $sformatf("rand%0d_out", i);
      check(nm, got, exp);
      nm = $sformatf("rand%0d_latency", i);
      check(nm, lat, LAT);
    end
    @(posedge sys_clk);
    #1 check("final_done_low", done_w, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
